// File: rtl/obstacle_pkg.sv
// Shared types and defaults for the obstacle RAM: FSM state encoding,
// default parameter values and the read-latency legality check.
package obstacle_pkg;

   localparam int DATA_W_DEF       = 32;
   localparam int ADDR_W_DEF       = 10;
   localparam int READ_LATENCY_DEF = 1;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   function automatic bit latency_ok(input int lat);
      return (lat == 1) || (lat == 2);
   endfunction

endpackage

// File: rtl/obstacle_ram_if.sv
// Avalon-MM slave (s1) and renderer scan-port bundle for obstacle_ram.
// The slave modport is the RAM side; master is the CPU/renderer side.
interface obstacle_ram_if
   import obstacle_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) ();

   logic [ADDR_W-1:0]   s1_address;
   logic                s1_chipselect;
   logic                s1_clken;
   logic                s1_write;
   logic [DATA_W-1:0]   s1_writedata;
   logic [DATA_W/8-1:0] s1_byteenable;
   logic                s1_waitrequest;
   logic [DATA_W-1:0]   s1_readdata;
   logic                s1_readdatavalid;

   logic                scan_req;
   logic [ADDR_W-1:0]   scan_addr;
   logic [DATA_W-1:0]   scan_data;
   logic                scan_valid;

   modport master (
      output s1_address, s1_chipselect, s1_clken, s1_write, s1_writedata, s1_byteenable,
      input  s1_waitrequest, s1_readdata, s1_readdatavalid,
      output scan_req, scan_addr,
      input  scan_data, scan_valid
   );

   modport slave (
      input  s1_address, s1_chipselect, s1_clken, s1_write, s1_writedata, s1_byteenable,
      output s1_waitrequest, s1_readdata, s1_readdatavalid,
      input  scan_req, scan_addr,
      output scan_data, scan_valid
   );

endinterface

// File: rtl/obstacle_dpram.sv
// True dual-port byte-enabled RAM; both ports return the old word when a
// read and a write hit the same address in the same cycle.
module obstacle_dpram
   import obstacle_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rd_a,
   input  logic [DATA_W/8-1:0] be_a,
   input  logic [ADDR_W-1:0]   addr_a,
   input  logic [DATA_W-1:0]   wdata_a,
   output logic [DATA_W-1:0]   q_a,
   input  logic                rd_b,
   input  logic [DATA_W/8-1:0] be_b,
   input  logic [ADDR_W-1:0]   addr_b,
   input  logic [DATA_W-1:0]   wdata_b,
   output logic [DATA_W-1:0]   q_b
);

   localparam int NB = DATA_W / 8;

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // NOTE: the array has no reset; it is zeroed by the clear walk in the top.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (be_a[i]) mem[addr_a][i*8 +: 8] <= wdata_a[i*8 +: 8];
         if (be_b[i]) mem[addr_b][i*8 +: 8] <= wdata_b[i*8 +: 8];
      end
   end

   // NOTE: non-blocking reads sample mem before this edge's writes land,
   // which is what gives old-data read-during-write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_a <= '0;
         q_b <= '0;
      end else begin
         if (rd_a) q_a <= mem[addr_a];
         if (rd_b) q_b <= mem[addr_b];
      end
   end

endmodule

// File: rtl/obstacle_ram.sv
// Obstacle map RAM: Avalon-MM slave port, renderer scan port and a zero-fill
// clear FSM. Define OBSTACLE_SCROLL_EN to add a scroll offset on scan reads.
module obstacle_ram
   import obstacle_pkg::*;
#(
   parameter int DATA_W       = DATA_W_DEF,
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int READ_LATENCY = READ_LATENCY_DEF
) (
   input  logic          clk_clk,
   input  logic          reset_reset,
   obstacle_ram_if.slave bus,
   input  logic          clear_req,
   output logic          busy
`ifdef OBSTACLE_SCROLL_EN
   ,
   input  logic              scroll_load,
   input  logic [ADDR_W-1:0] scroll_value
`endif
);

   localparam int NB = DATA_W / 8;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   cnt;
   logic                clearing;
   logic                s1_accept, s1_rd, s1_wr;
   logic [ADDR_W-1:0]   ram_addr_a;
   logic [NB-1:0]       ram_be_a;
   logic [DATA_W-1:0]   ram_wdata_a;
   logic [DATA_W-1:0]   q_a, q_b;
   logic [ADDR_W-1:0]   scan_phys;
   logic                scan_valid_q;

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= (state == CLEAR && !clear_req) ? cnt + ADDR_W'(1) : '0;
      end
   end

   always_comb begin
      // NOTE: default assignment first so this block cannot infer a latch.
      state_nxt = state;
      case (state)
         CLEAR:   if (!clear_req && cnt == '1) state_nxt = IDLE;
         IDLE:    if (clear_req) state_nxt = CLEAR;
         default: state_nxt = CLEAR;
      endcase
   end

   always_comb begin
      clearing           = (state == CLEAR);
      busy               = clearing;
      bus.s1_waitrequest = clearing;
   end

   // Port A is shared: the clear walk owns it in CLEAR, s1 in IDLE.
   assign s1_accept   = bus.s1_chipselect & bus.s1_clken & ~clearing;
   assign s1_rd       = s1_accept & ~bus.s1_write;
   assign s1_wr       = s1_accept &  bus.s1_write;
   assign ram_addr_a  = clearing ? cnt : bus.s1_address;
   assign ram_be_a    = clearing ? '1 : (s1_wr ? bus.s1_byteenable : '0);
   assign ram_wdata_a = clearing ? '0 : bus.s1_writedata;

`ifdef OBSTACLE_SCROLL_EN
   logic [ADDR_W-1:0] scroll_base;

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset)      scroll_base <= '0;
      else if (scroll_load) scroll_base <= scroll_value;
   end

   assign scan_phys = bus.scan_addr + scroll_base;
`else
   assign scan_phys = bus.scan_addr;
`endif

   obstacle_dpram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_dpram (
      .clk     (clk_clk),
      .rst     (reset_reset),
      .rd_a    (s1_rd),
      .be_a    (ram_be_a),
      .addr_a  (ram_addr_a),
      .wdata_a (ram_wdata_a),
      .q_a     (q_a),
      .rd_b    (bus.scan_req),
      .be_b    ('0),
      .addr_b  (scan_phys),
      .wdata_b ('0),
      .q_b     (q_b)
   );

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) scan_valid_q <= 1'b0;
      else             scan_valid_q <= bus.scan_req;
   end

   assign bus.scan_valid = scan_valid_q;
   assign bus.scan_data  = q_b;

   generate
      if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
         $error("obstacle_ram: READ_LATENCY must be 1 or 2");
      end

      if (READ_LATENCY == 2) begin : g_lat2
         logic [1:0]        vld;
         logic [DATA_W-1:0] data_q;

         // Extra data stage only loads on a returning read, so the output holds.
         always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
               vld    <= '0;
               data_q <= '0;
            end else begin
               vld <= {vld[0], s1_rd};
               if (vld[0]) data_q <= q_a;
            end
         end

         assign bus.s1_readdatavalid = vld[1];
         assign bus.s1_readdata      = data_q;
      end else begin : g_lat1
         logic vld;

         always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) vld <= 1'b0;
            else             vld <= s1_rd;
         end

         assign bus.s1_readdatavalid = vld;
         assign bus.s1_readdata      = q_a;
      end
   endgenerate

endmodule

// File: tb/tb_obstacle_ram.sv
// Directed bench for obstacle_ram: one instance at READ_LATENCY 1 and one at 2
// share the same stimulus. Define OBSTACLE_SCROLL_EN to cover the scroll offset.
`timescale 1ns/1ps
module tb_obstacle_ram;

   logic        clk;
   logic        rst;
   logic [9:0]  s1_address;
   logic        s1_chipselect;
   logic        s1_clken;
   logic        s1_write;
   logic [31:0] s1_writedata;
   logic [3:0]  s1_byteenable;
   logic        scan_req;
   logic [9:0]  scan_addr;
   logic        clear_req;
   logic        busy1, busy2;
`ifdef OBSTACLE_SCROLL_EN
   logic        scroll_load;
   logic [9:0]  scroll_value;
`endif

   int n_checks = 0;
   int n_errors = 0;

   obstacle_ram_if #(.DATA_W(32), .ADDR_W(10)) bus1 ();
   obstacle_ram_if #(.DATA_W(32), .ADDR_W(10)) bus2 ();

   assign bus1.s1_address    = s1_address;
   assign bus1.s1_chipselect = s1_chipselect;
   assign bus1.s1_clken      = s1_clken;
   assign bus1.s1_write      = s1_write;
   assign bus1.s1_writedata  = s1_writedata;
   assign bus1.s1_byteenable = s1_byteenable;
   assign bus1.scan_req      = scan_req;
   assign bus1.scan_addr     = scan_addr;
   assign bus2.s1_address    = s1_address;
   assign bus2.s1_chipselect = s1_chipselect;
   assign bus2.s1_clken      = s1_clken;
   assign bus2.s1_write      = s1_write;
   assign bus2.s1_writedata  = s1_writedata;
   assign bus2.s1_byteenable = s1_byteenable;
   assign bus2.scan_req      = scan_req;
   assign bus2.scan_addr     = scan_addr;

   obstacle_ram #(.DATA_W(32), .ADDR_W(10), .READ_LATENCY(1)) u_dut1 (
      .clk_clk     (clk),
      .reset_reset (rst),
      .bus         (bus1),
      .clear_req   (clear_req),
      .busy        (busy1)
`ifdef OBSTACLE_SCROLL_EN
      ,
      .scroll_load  (scroll_load),
      .scroll_value (scroll_value)
`endif
   );

   obstacle_ram #(.DATA_W(32), .ADDR_W(10), .READ_LATENCY(2)) u_dut2 (
      .clk_clk     (clk),
      .reset_reset (rst),
      .bus         (bus2),
      .clear_req   (clear_req),
      .busy        (busy2)
`ifdef OBSTACLE_SCROLL_EN
      ,
      .scroll_load  (scroll_load),
      .scroll_value (scroll_value)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy1 && n < 2000) begin
         tick();
         n++;
      end
   endtask

   task automatic s1_wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be, input logic ce);
      s1_address    = a;
      s1_writedata  = d;
      s1_byteenable = be;
      s1_write      = 1'b1;
      s1_chipselect = 1'b1;
      s1_clken      = ce;
      tick();
      s1_chipselect = 1'b0;
      s1_write      = 1'b0;
      s1_clken      = 1'b1;
   endtask

   // Single read: latency-1 instance answers after one edge, latency-2 after two.
   task automatic s1_rd(input logic [9:0] a, input logic [31:0] exp, input string tag);
      s1_address    = a;
      s1_write      = 1'b0;
      s1_chipselect = 1'b1;
      s1_clken      = 1'b1;
      tick();
      s1_chipselect = 1'b0;
      check({tag, "_rv1"}, 32'(bus1.s1_readdatavalid), 32'd1);
      check({tag, "_rd1"}, bus1.s1_readdata, exp);
      check({tag, "_rv2_early"}, 32'(bus2.s1_readdatavalid), 32'd0);
      tick();
      check({tag, "_rv1_pulse"}, 32'(bus1.s1_readdatavalid), 32'd0);
      check({tag, "_rv2"}, 32'(bus2.s1_readdatavalid), 32'd1);
      check({tag, "_rd2"}, bus2.s1_readdata, exp);
      tick();
      check({tag, "_rv2_pulse"}, 32'(bus2.s1_readdatavalid), 32'd0);
   endtask

   initial begin
      int          n;
      logic        bad;
      logic [9:0]  ba [3];
      logic [31:0] bexp [3];

      rst = 1'b1;
      s1_address = '0; s1_chipselect = 1'b0; s1_clken = 1'b1; s1_write = 1'b0;
      s1_writedata = '0; s1_byteenable = '0;
      scan_req = 1'b0; scan_addr = '0; clear_req = 1'b0;
`ifdef OBSTACLE_SCROLL_EN
      scroll_load = 1'b0; scroll_value = '0;
`endif
      repeat (3) tick();

      check("rst_busy1",  32'(busy1), 32'd1);
      check("rst_busy2",  32'(busy2), 32'd1);
      check("rst_wait1",  32'(bus1.s1_waitrequest), 32'd1);
      check("rst_rv1",    32'(bus1.s1_readdatavalid), 32'd0);
      check("rst_rv2",    32'(bus2.s1_readdatavalid), 32'd0);
      check("rst_sv1",    32'(bus1.scan_valid), 32'd0);
      check("rst_rd1",    bus1.s1_readdata, 32'd0);
      check("rst_rd2",    bus2.s1_readdata, 32'd0);
      check("rst_sd1",    bus1.scan_data, 32'd0);

      // Post-reset clear must last exactly 2**ADDR_W cycles.
      rst = 1'b0;
      count_busy(n);
      check("clear_len", 32'(n), 32'd1024);
      check("busy2_idle", 32'(busy2), 32'd0);
      check("wait1_idle", 32'(bus1.s1_waitrequest), 32'd0);

      s1_rd(10'd5,    32'h0, "rd5_zero");
      s1_rd(10'd1023, 32'h0, "rd1023_zero");

      s1_wr(10'd5, 32'hDEADBEEF, 4'b0101, 1'b1);
      s1_rd(10'd5, 32'h00AD00EF, "be0101");
      s1_wr(10'd5, 32'hFFFFFFFF, 4'b0000, 1'b1);
      s1_wr(10'd5, 32'hFFFFFFFF, 4'b1111, 1'b0);
      s1_rd(10'd5, 32'h00AD00EF, "be0_clken0");
      s1_wr(10'd1023, 32'h12345678, 4'b1111, 1'b1);
      s1_rd(10'd1023, 32'h12345678, "rd1023_full");

      // Scan and s1 write collide on address 7: scan sees the old word.
      scan_req = 1'b1; scan_addr = 10'd7;
      s1_wr(10'd7, 32'h1, 4'b1111, 1'b1);
      check("coll_sv",  32'(bus1.scan_valid), 32'd1);
      check("coll_old", bus1.scan_data, 32'h0);
      tick();
      check("coll_new", bus1.scan_data, 32'h1);
      scan_req = 1'b0;
      scan_addr = 10'd5;
      tick();
      check("scan_pulse", 32'(bus1.scan_valid), 32'd0);
      check("scan_hold",  bus1.scan_data, 32'h1);

      // Back-to-back reads.
      ba[0] = 10'd5; ba[1] = 10'd7; ba[2] = 10'd8;
      bexp[0] = 32'h00AD00EF; bexp[1] = 32'h1; bexp[2] = 32'h0;
      s1_write = 1'b0; s1_clken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s1_address = ba[i];
         s1_chipselect = 1'b1;
         tick();
         check("b2b_rv1", 32'(bus1.s1_readdatavalid), 32'd1);
         check("b2b_rd1", bus1.s1_readdata, bexp[i]);
         if (i > 0) begin
            check("b2b_rv2", 32'(bus2.s1_readdatavalid), 32'd1);
            check("b2b_rd2", bus2.s1_readdata, bexp[i-1]);
         end else begin
            check("b2b_rv2_first", 32'(bus2.s1_readdatavalid), 32'd0);
         end
      end
      s1_chipselect = 1'b0;
      tick();
      check("b2b_rv1_end", 32'(bus1.s1_readdatavalid), 32'd0);
      check("b2b_rd1_hold", bus1.s1_readdata, bexp[2]);
      check("b2b_rv2_last", 32'(bus2.s1_readdatavalid), 32'd1);
      check("b2b_rd2_last", bus2.s1_readdata, bexp[2]);
      tick();
      check("b2b_rv2_end", 32'(bus2.s1_readdatavalid), 32'd0);

`ifdef OBSTACLE_SCROLL_EN
      s1_wr(10'd6, 32'hCAFE0006, 4'b1111, 1'b1);
      scroll_load = 1'b1; scroll_value = 10'd1020;
      scan_req = 1'b1; scan_addr = 10'd10;
      tick();
      scroll_load = 1'b0;
      check("scroll_same_cycle", bus1.scan_data, 32'h0);
      tick();
      check("scroll_wrap", bus1.scan_data, 32'hCAFE0006);
      scan_req = 1'b0;
      scroll_load = 1'b1; scroll_value = 10'd0;
      tick();
      scroll_load = 1'b0;
`endif

      // Clear request from IDLE, scan during CLEAR, restart at counter 300.
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      check("clr_busy", 32'(busy1), 32'd1);
      scan_req = 1'b1; scan_addr = 10'd7;
      tick();
      scan_req = 1'b0;
      check("clr_scan_sv", 32'(bus1.scan_valid), 32'd1);
      check("clr_scan_sd", bus1.scan_data, 32'h1);
      repeat (299) tick();
      clear_req = 1'b1;
      s1_address = 10'd5; s1_write = 1'b0; s1_clken = 1'b1; s1_chipselect = 1'b1;
      tick();
      clear_req = 1'b0;
      n = 0;
      bad = 1'b0;
      while (busy1 && n < 2000) begin
         if (!bus1.s1_waitrequest || !bus2.s1_waitrequest ||
             bus1.s1_readdatavalid || bus2.s1_readdatavalid) bad = 1'b1;
         tick();
         n++;
      end
      s1_chipselect = 1'b0;
      check("restart_len", 32'(n), 32'd1024);
      check("restart_stall", 32'(bad), 32'd0);
      s1_rd(10'd5, 32'h0, "after_clr5");
      s1_rd(10'd7, 32'h0, "after_clr7");

      // Reset during back-to-back reads must flush the pipeline.
      s1_wr(10'd3, 32'h33, 4'b1111, 1'b1);
      s1_address = 10'd3; s1_write = 1'b0; s1_chipselect = 1'b1;
      scan_req = 1'b1; scan_addr = 10'd3;
      repeat (3) tick();
      rst = 1'b1;
      #1;
      check("mid_rst_rv1", 32'(bus1.s1_readdatavalid), 32'd0);
      check("mid_rst_rv2", 32'(bus2.s1_readdatavalid), 32'd0);
      check("mid_rst_rd2", bus2.s1_readdata, 32'h0);
      check("mid_rst_sv",  32'(bus1.scan_valid), 32'd0);
      check("mid_rst_busy", 32'(busy1), 32'd1);
      tick();
      rst = 1'b0;
      s1_chipselect = 1'b0;
      scan_req = 1'b0;
      bad = 1'b0;
      repeat (4) begin
         tick();
         if (bus1.s1_readdatavalid || bus2.s1_readdatavalid) bad = 1'b1;
      end
      check("flush_no_rv", 32'(bad), 32'd0);

      // Reset in the middle of a clear restarts it from address 0.
      repeat (100) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      count_busy(n);
      check("rst_mid_clear_len", 32'(n), 32'd1024);
      s1_rd(10'd3, 32'h0, "after_rst3");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/obstacle_ram.md
OBSTACLE_RAM -- requirements
Module: obstacle_ram

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 10, word address width; depth SHALL be 2**ADDR_W.
REQ-003 Parameter READ_LATENCY, default 1, Avalon read latency in cycles; legal values 1 or 2.
REQ-004 clk_clk  in  1  sole clock; all logic rising-edge.
REQ-005 reset_reset  in  1  asynchronous, active-high reset.
REQ-006 s1_address  in  ADDR_W  Avalon-MM word address.
REQ-007 s1_chipselect  in  1  access select.
REQ-008 s1_clken  in  1  access enable; low ignores the s1 access.
REQ-009 s1_write  in  1  1 = write, 0 = read.
REQ-010 s1_writedata  in  DATA_W  write data.
REQ-011 s1_byteenable  in  DATA_W/8  per-byte write enable.
REQ-012 s1_waitrequest  out  1  high while the s1 access is not accepted.
REQ-013 s1_readdata  out  DATA_W  read data.
REQ-014 s1_readdatavalid  out  1  one-cycle qualifier for s1_readdata.
REQ-015 scan_req  in  1  renderer read request.
REQ-016 scan_addr  in  ADDR_W  renderer logical address.
REQ-017 scan_data  out  DATA_W  renderer read data.
REQ-018 scan_valid  out  1  one-cycle qualifier for scan_data.
REQ-019 clear_req  in  1  single-cycle pulse requesting a full-memory zero fill.
REQ-020 busy  out  1  high while a clear is in progress.

Function
REQ-021 The block SHALL use states CLEAR and IDLE; CLEAR walks a counter 0..2**ADDR_W-1 writing all-zero words, one word per cycle.
REQ-022 CLEAR SHALL go to IDLE the cycle after writing the last address; IDLE SHALL go to CLEAR on clear_req; clear_req during CLEAR SHALL restart the counter at 0.
REQ-023 busy and s1_waitrequest SHALL be high in CLEAR and low in IDLE, so a full clear takes exactly 2**ADDR_W cycles.
REQ-024 An s1 access SHALL be accepted when s1_chipselect & s1_clken & !s1_waitrequest.
REQ-025 An accepted write SHALL update only bytes with s1_byteenable set; byteenable 0 SHALL leave the word unchanged.
REQ-026 An accepted read SHALL raise s1_readdatavalid exactly READ_LATENCY cycles later, one pulse per read, back-to-back reads fully pipelined.
REQ-027 s1_readdata SHALL hold its last value when s1_readdatavalid is low.
REQ-028 scan_req SHALL be serviced in every state with 1-cycle latency: scan_valid high the cycle after scan_req; during CLEAR scan_data SHALL be whatever the memory holds.
REQ-029 When a scan read and an s1 write or clear write hit the same address in the same cycle, scan_data SHALL return the old word.
REQ-030 Addresses SHALL wrap modulo 2**ADDR_W; there are no out-of-range accesses.

Reset
REQ-031 Reset SHALL force state CLEAR, counter 0, busy 1, s1_waitrequest 1, s1_readdatavalid 0, scan_valid 0, s1_readdata 0, scan_data 0, and SHALL flush in-flight reads.
REQ-032 Reset asserted mid-clear SHALL restart the clear from address 0 after release.
REQ-033 Memory contents SHALL NOT be reset directly; they are zeroed by the post-reset CLEAR.

Configuration
REQ-034 Macro OBSTACLE_SCROLL_EN SHALL add inputs scroll_load (1) and scroll_value (ADDR_W) and an ADDR_W scroll_base register, reset to 0, loaded on scroll_load.
REQ-035 With OBSTACLE_SCROLL_EN defined, the scan physical address SHALL be (scan_addr + scroll_base) mod 2**ADDR_W, and a load SHALL affect scan requests from the next cycle; s1 addressing SHALL be unaffected.
REQ-036 Without the macro, those ports and the register SHALL be absent and the scan physical address SHALL equal scan_addr.

Structure
REQ-037 Package obstacle_pkg SHALL hold the state enum, default parameter constants and the READ_LATENCY legality check.
REQ-038 Sub-module obstacle_dpram SHALL implement the true dual-port byte-enabled RAM with old-data read-during-write; the FSM and latency pipeline stay in the top.

Verification
REQ-039 Release reset with ADDR_W=10 -> busy high for exactly 1024 cycles; afterwards a read of any address returns 0.
REQ-040 Write 0xDEADBEEF to addr 5 with byteenable 4'b0101 over zero -> a later read of addr 5 returns 0x00AD00EF, with readdatavalid exactly READ_LATENCY cycles after acceptance.
REQ-041 Scan addr 7 and s1 write 0x1 to addr 7 in the same cycle (old word 0x0) -> scan_data 0x0; the next scan returns 0x1.
REQ-042 clear_req at counter 300 -> busy stays high 1024 more cycles and s1 requests stall on waitrequest throughout.
REQ-043 With OBSTACLE_SCROLL_EN, scroll_value 1020 loaded and scan_addr 10 -> returns the word at address 6.
REQ-044 Assert reset during 4 back-to-back reads with READ_LATENCY=2 -> no readdatavalid pulse after reset release.
